niox_ram_bytelane: RTL and testbench



---
 rtl/niox_ram_pkg.sv | 19 +
 rtl/niox_ram_byte_bank.sv | 39 +++
 rtl/niox_ram_bytelane.sv | 125 ++++++++++++
 tb/tb_niox_ram_bytelane.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/niox_ram_pkg.sv
// niox_ram_pkg: shared types and helpers for the niox byte-lane RAM.
//   state_t   : top-level sequencer states (sweep-clear vs. normal run)
//   BYTE_W    : width of one byte lane
//   lane_lsb  : bit offset of a byte lane inside a word
package niox_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int BYTE_W = 8;

   // Lane i of a word occupies word[lane_lsb(i) +: BYTE_W].
   function automatic int lane_lsb(input int lane);
      return lane * BYTE_W;
   endfunction

endpackage

// File: rtl/niox_ram_byte_bank.sv
// niox_ram_byte_bank: one 8-bit x 2^ADDR_W write-first storage bank.
//   clk  : rising-edge clock
//   en   : access enable (read or write)
//   we   : write this lane (only meaningful with en)
//   addr : word address
//   din  : lane write data
//   dout : registered lane data; on a write it returns the written byte,
//          and it holds its value while en=0
// The array and its output register carry no reset so the storage maps
// onto plain block RAM.
module niox_ram_byte_bank
   import niox_ram_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout
);

   localparam int D = 1 << ADDR_W;

   logic [BYTE_W-1:0] mem [D];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= din;
            dout      <= din;
         end else begin
            dout      <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/niox_ram_bytelane.sv
// niox_ram_bytelane: single-port word RAM with per-byte write enables,
// write-first read data, optional output register and post-reset clear.
//   clk, reset   : clock and synchronous active-high reset
//   req, we, be  : access request, write select, byte-lane write enables
//   addr, din    : word address and write data
//   ready        : request accepted this cycle when req=1
//   dout         : read data (merged post-write word for writes), held
//                  between results
//   dout_valid   : one-cycle pulse per new result (latency 1+OUT_REG)
//   init_busy    : clearing sweep in progress
module niox_ram_bytelane
   import niox_ram_pkg::*;
#(
   parameter int DATA_BYTES     = 4,
   parameter int ADDR_W         = 12,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req,
   input  logic                         we,
   input  logic [DATA_BYTES-1:0]        be,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_BYTES*BYTE_W-1:0] din,
   output logic                         ready,
   output logic [DATA_BYTES*BYTE_W-1:0] dout,
   output logic                         dout_valid,
   output logic                         init_busy
);

   localparam int W      = DATA_BYTES * BYTE_W;
   // Bank register is stage 0, optional mid register next, dout last.
   localparam int STAGES = 1 + OUT_REG;

   state_t                               state, state_nxt;
   logic [ADDR_W-1:0]                    clr_cnt;
   logic                                 clearing, acc, bank_en;
   logic [ADDR_W-1:0]                    bank_addr;
   logic [DATA_BYTES-1:0]                lane_we;
   logic [DATA_BYTES-1:0][BYTE_W-1:0]    lane_din, bank_q;
   logic [W-1:0]                         res_src;
   logic [STAGES:0]                      vld_pipe;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == '1) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)         clr_cnt <= '0;
      else if (clearing) clr_cnt <= clr_cnt + 1'b1;
   end

   assign ready     = (state == RUN);
   assign init_busy = (state == CLEAR);

   // Keep the array untouched on the cycle reset is sampled.
   assign clearing  = init_busy & ~reset;
   assign acc       = req & ready & ~reset;
   assign bank_en   = clearing | acc;
   assign bank_addr = clearing ? clr_cnt : addr;

   // Clear forces every lane to write zero; a normal access writes only
   // enabled lanes, the rest read back so the bank outputs form the
   // merged post-write word.
   always_comb begin
      lane_we  = '0;
      lane_din = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         lane_we[i]  = clearing | (acc & we & be[i]);
         lane_din[i] = clearing ? '0 : din[lane_lsb(i) +: BYTE_W];
      end
   end

   for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
      niox_ram_byte_bank #(
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk  (clk),
         .en   (bank_en),
         .we   (lane_we[i]),
         .addr (bank_addr),
         .din  (lane_din[i]),
         .dout (bank_q[i])
      );
   end

   // ---------------- result pipeline ----------------
   always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[STAGES-1:0], acc};
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [W-1:0] mid_q;
      always_ff @(posedge clk) begin
         if (reset)            mid_q <= '0;
         else if (vld_pipe[0]) mid_q <= bank_q;
      end
      assign res_src = mid_q;
   end else begin : g_noreg
      assign res_src = bank_q;
   end

   // dout only loads on a real result, so it holds across idle and
   // clear cycles even though the banks keep moving underneath.
   always_ff @(posedge clk) begin
      if (reset)                   dout <= '0;
      else if (vld_pipe[STAGES-1]) dout <= res_src;
   end

   assign dout_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_niox_ram_bytelane.sv
module tb_niox_ram_bytelane;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req01, req2, we;
   logic [3:0]  be;
   logic [3:0]  addr;
   logic [31:0] din;

   logic        ready0, dv0, busy0;
   logic        ready1, dv1, busy1;
   logic        ready2, dv2, busy2;
   logic [31:0] dout0, dout1, dout2;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          busy_cnt = 0;

   exp_t        q0[$], q1[$], q2[$];
   logic [31:0] m  [16];   // model shared by u0/u1 (identical traffic)
   logic [31:0] m2 [16];   // model for u2 (no clear: starts unknown)

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   niox_ram_bytelane #(.DATA_BYTES(4), .ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
      .clk(clk), .reset(rst), .req(req01), .we(we), .be(be), .addr(addr), .din(din),
      .ready(ready0), .dout(dout0), .dout_valid(dv0), .init_busy(busy0));

   niox_ram_bytelane #(.DATA_BYTES(4), .ADDR_W(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
      .clk(clk), .reset(rst), .req(req01), .we(we), .be(be), .addr(addr), .din(din),
      .ready(ready1), .dout(dout1), .dout_valid(dv1), .init_busy(busy1));

   niox_ram_bytelane #(.DATA_BYTES(4), .ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
      .clk(clk), .reset(rst), .req(req2), .we(we), .be(be), .addr(addr), .din(din),
      .ready(ready2), .dout(dout2), .dout_valid(dv2), .init_busy(busy2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] b);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // Scoreboard: pop one expectation per dout_valid pulse.
   task automatic sb(input string tag, input bit have, input exp_t e,
                     input logic [31:0] d, input int lat);
      chk({tag, " pending"}, 32'(have), 32'd1);
      if (have) begin
         chk({tag, " data"}, d, e.d);
         chk({tag, " latency"}, 32'(cyc - e.c), 32'(lat));
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   have;
      if (busy0 && !rst) busy_cnt++;
      if (dv0) begin
         have = (q0.size() != 0);
         e = have ? q0.pop_front() : '{d: '0, c: 0};
         sb("u0", have, e, dout0, 1);
      end
      if (dv1) begin
         have = (q1.size() != 0);
         e = have ? q1.pop_front() : '{d: '0, c: 0};
         sb("u1", have, e, dout1, 2);
      end
      if (dv2) begin
         have = (q2.size() != 0);
         e = have ? q2.pop_front() : '{d: '0, c: 0};
         sb("u2", have, e, dout2, 1);
      end
   end

   // Drive one access for a cycle; expectations are queued only for DUTs
   // that will accept it.
   task automatic issue(input bit r01, input bit r2, input bit w, input logic [3:0] b,
                        input logic [3:0] a, input logic [31:0] d);
      logic [31:0] nw;
      req01 = r01; req2 = r2; we = w; be = b; addr = a; din = d;
      if (r01 && ready0) begin
         nw = merge(m[a], d, w ? b : 4'b0000);
         m[a] = nw;
         q0.push_back('{d: nw, c: cyc + 1});
         q1.push_back('{d: nw, c: cyc + 1});
      end
      if (r2 && ready2) begin
         nw = merge(m2[a], d, w ? b : 4'b0000);
         m2[a] = nw;
         q2.push_back('{d: nw, c: cyc + 1});
      end
      @(posedge clk); #1;
      req01 = 1'b0; req2 = 1'b0; we = 1'b0; be = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready0 && n < 40) begin @(posedge clk); #1; n++; end
      chk(tag, 32'(ready0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req01 = 1'b0; req2 = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
      for (int i = 0; i < 16; i++) m[i] = '0;
      idle(3);

      // Reset values.
      @(negedge clk);
      chk("rst ready0",  32'(ready0), 32'd0);
      chk("rst busy0",   32'(busy0),  32'd1);
      chk("rst dout0",   dout0,       32'd0);
      chk("rst dv0",     32'(dv0),    32'd0);
      chk("rst dout1",   dout1,       32'd0);
      chk("rst ready2",  32'(ready2), 32'd1);
      chk("rst busy2",   32'(busy2),  32'd0);

      // Release; u2 (no clear) is usable immediately while u0/u1 sweep.
      @(posedge clk); #1;
      rst = 1'b0; busy_cnt = 0;
      chk("u2 ready first cycle", 32'(ready2), 32'd1);
      issue(0, 1, 1, 4'hF, 4'd2, 32'hA5A5_A5A5);
      issue(0, 1, 0, 4'h0, 4'd2, 32'h0);
      wait_ready("sweep ends");
      chk("busy cycles", 32'(busy_cnt), 32'd16);

      // Whole array reads back zero.
      for (int i = 0; i < 16; i++) issue(1, 0, 0, 4'h0, 4'(i), 32'h0);
      idle(3);

      // Partial-lane write merge, write-first.
      issue(1, 0, 1, 4'b1111, 4'd5, 32'hDEAD_BEEF);
      issue(1, 0, 1, 4'b0101, 4'd5, 32'h1122_3344);
      issue(1, 0, 0, 4'b0000, 4'd5, 32'h0);
      idle(3);
      chk("merge model", m[5], 32'hDE22_BE44);

      // Distinct writes, then back-to-back reads 0..7.
      for (int i = 0; i < 8; i++)
         issue(1, 0, 1, 4'hF, 4'(i), (32'(i + 1) * 32'h0101_0000) | 32'h0000_00C3);
      for (int i = 0; i < 8; i++) issue(1, 0, 0, 4'h0, 4'(i), 32'h0);
      idle(3);

      // be=0 write leaves memory unchanged, still returns the word.
      issue(1, 0, 1, 4'hF, 4'd3, 32'hCAFE_F00D);
      issue(1, 0, 1, 4'h0, 4'd3, 32'h1234_5678);
      issue(1, 0, 0, 4'h0, 4'd3, 32'h0);
      idle(3);

      // Reset two cycles after a read: u1's result must be dropped.
      issue(1, 0, 0, 4'h0, 4'd5, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid-reset dv1",    32'(dv1),       32'd0);
      chk("mid-reset dout1",  dout1,          32'd0);
      chk("mid-reset pend1",  32'(q1.size()), 32'd1);
      chk("mid-reset busy0",  32'(busy0),     32'd1);
      q0.delete(); q1.delete();
      for (int i = 0; i < 16; i++) m[i] = '0;
      @(posedge clk); #1;
      rst = 1'b0; busy_cnt = 0;

      // Requests during the sweep are ignored.
      issue(1, 0, 1, 4'hF, 4'd7, 32'hFFFF_FFFF);
      wait_ready("sweep ends again");
      chk("busy cycles again", 32'(busy_cnt), 32'd16);
      for (int i = 0; i < 8; i++) issue(1, 0, 0, 4'h0, 4'(i), 32'h0);
      issue(1, 0, 0, 4'h0, 4'd5, 32'h0);
      idle(4);

      chk("q0 drained", 32'(q0.size()), 32'd0);
      chk("q1 drained", 32'(q1.size()), 32'd0);
      chk("q2 drained", 32'(q2.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
